// File: rtl/s35932_misr_compaction_ctrl.sv
// s35932_misr_compaction_ctrl
// Sequences a shared CRC/MISR signature register: seeds it, compacts a
// programmed number of words taken round-robin from NREQ requesters, then
// compares the result against a golden signature and reports pass/fail.
// Optional feature macro: MISR_TIMEOUT_EN. When it is defined, an idle
// watchdog runs in COMPACT and raises err.
module s35932_misr_compaction_ctrl #(
    parameter int unsigned       WIDTH   = 32,
    parameter int unsigned       NREQ    = 4,
    parameter logic [WIDTH-1:0]  POLY    = 32'h0001_0811,
    parameter int unsigned       CNT_W   = 16,
    parameter int unsigned       TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      seed,
    input  logic [WIDTH-1:0]      golden,
    input  logic [CNT_W-1:0]      word_count,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [WIDTH-1:0]      signature,
    output logic                  err
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_COMPACT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] sig_q,       sig_d;
    logic [WIDTH-1:0] seed_q,      seed_d;
    logic [WIDTH-1:0] golden_q,    golden_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [PTR_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             pass_q,      pass_d;
    logic             err_q,       err_d;

`ifdef MISR_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]  idle_cnt_q,  idle_cnt_d;
`endif

    logic [NREQ-1:0]  grant;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_found;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] sig_next;

    // Round-robin arbiter: first valid requester at or after the pointer
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
        if (state_q == ST_COMPACT && !abort && remaining_q != '0 && gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign xfer     = |grant;
    assign sel_data = req_data[32'(gnt_idx)*WIDTH +: WIDTH];
    assign sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ sel_data;

    // Next-state and datapath: abort wins over any same-cycle transfer
    always_comb begin
        state_d     = state_q;
        sig_d       = sig_q;
        seed_d      = seed_q;
        golden_d    = golden_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_d       = err_q;
`ifdef MISR_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d   = seed;
                    golden_d = golden;
                    count_d  = word_count;
                    pass_d   = 1'b0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_SEED;
                end
            end
            ST_SEED: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    sig_d       = seed_q;
                    remaining_d = count_q;
`ifdef MISR_TIMEOUT_EN
                    idle_cnt_d  = '0;
`endif
                    state_d     = (count_q == '0) ? ST_CHECK : ST_COMPACT;
                end
            end
            ST_COMPACT: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    sig_d       = sig_next;
                    remaining_d = remaining_q - CNT_W'(1);
                    rr_ptr_d    = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
`ifdef MISR_TIMEOUT_EN
                    idle_cnt_d  = '0;
`endif
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_CHECK;
                    end
                end else begin
`ifdef MISR_TIMEOUT_EN
                    idle_cnt_d = idle_cnt_q + TO_W'(1);
                    if (idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        pass_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    pass_d  = (sig_q == golden_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            sig_q       <= '0;
            seed_q      <= '0;
            golden_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef MISR_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            seed_q      <= seed_d;
            golden_q    <= golden_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
`ifdef MISR_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign req_ready = grant;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign err       = err_q;

endmodule

// File: tb/tb_s35932_misr_compaction_ctrl.sv
// Directed testbench for s35932_misr_compaction_ctrl (NREQ=4, WIDTH=32).
module tb_s35932_misr_compaction_ctrl;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         start;
    logic         abort;
    logic [31:0]  seed;
    logic [31:0]  golden;
    logic [15:0]  word_count;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         busy;
    logic         done;
    logic         pass;
    logic [31:0]  signature;
    logic         err;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    s35932_misr_compaction_ctrl #(
        .WIDTH   (32),
        .NREQ    (4),
        .POLY    (32'h0001_0811),
        .CNT_W   (16),
        .TIMEOUT (255)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .golden     (golden),
        .word_count (word_count),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h0001_0811 : 32'h0) ^ d;
    endfunction

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*32 +: 32] = d;
    endtask

    // Ends one #1 after the edge that samples start (state SEED).
    task automatic start_run(input logic [31:0] s, input logic [31:0] g, input logic [15:0] wc);
        @(posedge CLK); #1;
        start = 1'b1; seed = s; golden = g; word_count = wc;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    // n = cycle index (start cycle = 0) where done is seen; ng = grants observed.
    task automatic run(input logic [31:0] s, input logic [31:0] g, input logic [15:0] wc,
                       output int n, output int ng);
        start_run(s, g, wc);
        chk("pass_cleared", {31'b0, pass}, 32'd0);
        n = 1; ng = 0;
        while (!done && n < 400) begin
            if (req_ready != 4'b0) ng++;
            @(posedge CLK); #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, ng, k;
        logic [31:0] d [4];
        logic [31:0] g;
        logic [3:0]  e;

        RESET = 1'b0; start = 1'b0; abort = 1'b0;
        seed = '0; golden = '0; word_count = '0;
        req_valid = '0; req_data = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_sig",   signature, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_pass",  {31'b0, pass}, 32'd0);
        chk("rst_err",   {31'b0, err}, 32'd0);
        chk("rst_ready", {28'b0, req_ready}, 32'd0);
        RESET = 1'b1;

        // All four valid, 8 words: grant order 0,1,2,3,0,1,2,3; done at start+11
        d[0] = 32'hA5A5_0001; d[1] = 32'h0F0F_1234; d[2] = 32'h8000_0003; d[3] = 32'h7FFF_FFFF;
        for (int i = 0; i < 4; i++) set_data(i, d[i]);
        req_valid = 4'hF;
        g = 32'h1234_5678;
        for (int i = 0; i < 8; i++) g = step(g, d[i % 4]);
        start_run(32'h1234_5678, g, 16'd8);
        n = 1; k = 0;
        while (!done && n < 60) begin
            if (req_ready != 4'b0) begin
                e = 4'b0001 << (k % 4);
                chk("rr_grant", {28'b0, req_ready}, {28'b0, e});
                chk("busy_compact", {31'b0, busy}, 32'd1);
                k++;
            end
            @(posedge CLK); #1;
            n++;
        end
        chk("rr_done_lat", n, 32'd11);
        chk("rr_nwords",   k, 32'd8);
        chk("rr_sig",      signature, g);
        chk("rr_pass",     {31'b0, pass}, 32'd1);
        @(posedge CLK); #1;
        chk("done_pulse",  {31'b0, done}, 32'd0);
        chk("idle_busy",   {31'b0, busy}, 32'd0);
        chk("sig_hold",    signature, g);

        // Single word from req0, seed 0, data 1
        req_valid = 4'b0001; set_data(0, 32'h0000_0001);
        run(32'h0, 32'h0000_0001, 16'd1, n, ng);
        chk("w1_sig",  signature, 32'h0000_0001);
        chk("w1_pass", {31'b0, pass}, 32'd1);
        chk("w1_lat",  n, 32'd4);

        // Feedback path: MSB set, zero data; req3 only (pointer wraps to 0)
        req_valid = 4'b1000; set_data(3, 32'h0);
        run(32'h8000_0000, 32'h0001_0811, 16'd1, n, ng);
        chk("fb_sig",  signature, 32'h0001_0811);
        chk("fb_pass", {31'b0, pass}, 32'd1);
        run(32'h8000_0000, 32'h0, 16'd1, n, ng);
        chk("fb_mis_pass", {31'b0, pass}, 32'd0);

        // Zero words: no grants, done at start+3
        req_valid = 4'hF;
        run(32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd0, n, ng);
        chk("z_lat",    n, 32'd3);
        chk("z_grants", ng, 32'd0);
        chk("z_sig",    signature, 32'hDEAD_BEEF);
        chk("z_pass",   {31'b0, pass}, 32'd1);

        // Abort on 3rd of 5 words; valid 1010 skips idle requesters; start mid-run ignored
        req_valid = 4'b1010; set_data(1, 32'h0000_00F0); set_data(3, 32'h0000_000F);
        start_run(32'h0, 32'h0, 16'd5);
        @(posedge CLK); #1;
        chk("ab_g1", {28'b0, req_ready}, 32'h2);
        start = 1'b1; seed = 32'hFFFF_FFFF; word_count = 16'd1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("ab_g2", {28'b0, req_ready}, 32'h8);
        chk("ab_busy", {31'b0, busy}, 32'd1);
        @(posedge CLK); #1;
        abort = 1'b1;
        #1;
        chk("ab_ready0", {28'b0, req_ready}, 32'd0);
        @(posedge CLK); #1;
        abort = 1'b0;
        chk("ab_busy0", {31'b0, busy}, 32'd0);
        chk("ab_sig",   signature, 32'h0000_01EF);
        chk("ab_pass",  {31'b0, pass}, 32'd0);
        chk("ab_ready", {28'b0, req_ready}, 32'd0);
        ng = 0;
        repeat (6) begin
            if (done) ng++;
            @(posedge CLK); #1;
        end
        chk("ab_nodone", ng, 32'd0);

        // Stall with nothing valid
        req_valid = 4'b0;
`ifdef MISR_TIMEOUT_EN
        run(32'h0, 32'h0, 16'd2, n, ng);
        chk("to_done", {31'b0, done}, 32'd1);
        chk("to_err",  {31'b0, err}, 32'd1);
        chk("to_pass", {31'b0, pass}, 32'd0);
        run(32'h5, 32'h5, 16'd0, n, ng);
        chk("to_err_clr", {31'b0, err}, 32'd0);
`else
        start_run(32'h0, 32'h0, 16'd2);
        repeat (20) @(posedge CLK);
        #1;
        chk("st_err",   {31'b0, err}, 32'd0);
        chk("st_busy",  {31'b0, busy}, 32'd1);
        chk("st_done",  {31'b0, done}, 32'd0);
        chk("st_ready", {28'b0, req_ready}, 32'd0);
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        chk("st_abort_busy", {31'b0, busy}, 32'd0);
`endif

        // Reset asserted mid-run
        req_valid = 4'hF;
        start_run(32'h1111_2222, 32'h0, 16'd5);
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("mr_sig",   signature, 32'd0);
        chk("mr_busy",  {31'b0, busy}, 32'd0);
        chk("mr_ready", {28'b0, req_ready}, 32'd0);
        chk("mr_done",  {31'b0, done}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("mr_idle_busy", {31'b0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
